// File: rtl/sar_ctrl_pkg.sv
// Shared types and helpers for the successive-approximation controller.
// The state encoding and the latency helper are used by both the RTL and
// any environment that needs to know how long a conversion takes.
package sar_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DECIDE = 2'd2,
        FINISH = 2'd3
    } sar_state_t;

    // Extra wait added to every bit when the comparator is resynchronised.
    localparam int SYNC_STAGES = 2;

    // Edges from the start-sampling edge to the edge after which done is high.
    function automatic int sar_latency(input int n, input int settle, input bit sync);
        int per_bit;
        if (sync) begin
            per_bit = settle + SYNC_STAGES + 1;
        end else begin
            per_bit = settle + 1;
        end
        return n * per_bit + 1;
    endfunction

endpackage

// File: rtl/sar_ctrl_sync_2ff.sv
// Two-flop synchronizer for the comparator decision. Only built into the
// design when SAR_CTRL_CMP_SYNC_EN is defined, so the default build carries
// no unused module.
`ifdef SAR_CTRL_CMP_SYNC_EN
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    import sar_ctrl_pkg::*;

    logic meta_r;
    logic sync_r;

    // Two back-to-back flops; the first may go metastable, the second is used.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule
`endif

// File: rtl/sar_ctrl.sv
// Successive-approximation controller: drives a trial code MSB-first, waits
// for the DAC/comparator to settle, samples cmp_lt (input below trial code)
// and clears the trial bit when the input is lower.
// Build option: SAR_CTRL_CMP_SYNC_EN routes cmp_lt through a 2-flop
// synchronizer and lengthens every per-bit wait by two cycles.
module sar_ctrl #(
    parameter int N      = 8,
    parameter int SETTLE = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         cmp_lt,
    output logic [N-1:0] dac_code,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result
);
    // Imported after the parameter list so the SETTLE parameter keeps its
    // name; the SETTLE state is referenced with the package scope.
    import sar_ctrl_pkg::*;

`ifdef SAR_CTRL_CMP_SYNC_EN
    localparam int WAIT_CYC = SETTLE + SYNC_STAGES;
`else
    localparam int WAIT_CYC = SETTLE;
`endif
    localparam int            CW       = $clog2(WAIT_CYC + 2);
    localparam int            IW       = $clog2(N);
    localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_CYC);
    localparam logic [IW-1:0] IDX_TOP  = IW'(N - 1);
    localparam logic [N-1:0]  MSB_CODE = {1'b1, {(N-1){1'b0}}};
    localparam sar_state_t    AFTER_TRIAL = (WAIT_CYC > 0) ? sar_ctrl_pkg::SETTLE : DECIDE;

    sar_state_t    state_r;
    sar_state_t    state_nxt_s;
    logic [N-1:0]  code_r;
    logic [N-1:0]  code_nxt_s;
    logic [IW-1:0] idx_r;
    logic [IW-1:0] idx_nxt_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_nxt_s;
    logic          busy_r;
    logic          busy_nxt_s;
    logic          done_r;
    logic          done_nxt_s;
    logic [N-1:0]  result_r;
    logic [N-1:0]  result_nxt_s;
    logic          cmp_use_s;

`ifdef SAR_CTRL_CMP_SYNC_EN
    sync_2ff u_cmp_sync (
        .clk (clk),
        .rst (rst),
        .d   (cmp_lt),
        .q   (cmp_use_s)
    );
`else
    assign cmp_use_s = cmp_lt;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Datapath and output registers; a reset aborts any conversion silently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            code_r   <= {N{1'b0}};
            idx_r    <= IDX_TOP;
            cnt_r    <= {CW{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            result_r <= {N{1'b0}};
        end else begin
            code_r   <= code_nxt_s;
            idx_r    <= idx_nxt_s;
            cnt_r    <= cnt_nxt_s;
            busy_r   <= busy_nxt_s;
            done_r   <= done_nxt_s;
            result_r <= result_nxt_s;
        end
    end

    // Next-state and next-register values for the SAR sequence.
    always_comb begin
        state_nxt_s  = state_r;
        code_nxt_s   = code_r;
        idx_nxt_s    = idx_r;
        cnt_nxt_s    = cnt_r;
        busy_nxt_s   = busy_r;
        done_nxt_s   = 1'b0;
        result_nxt_s = result_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    code_nxt_s  = MSB_CODE;
                    idx_nxt_s   = IDX_TOP;
                    cnt_nxt_s   = CNT_LOAD;
                    busy_nxt_s  = 1'b1;
                    state_nxt_s = AFTER_TRIAL;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            sar_ctrl_pkg::SETTLE: begin
                // The comparator output is not trusted until the count runs out.
                if (cnt_r <= CW'(1)) begin
                    cnt_nxt_s   = {CW{1'b0}};
                    state_nxt_s = DECIDE;
                end else begin
                    cnt_nxt_s   = cnt_r - CW'(1);
                    state_nxt_s = sar_ctrl_pkg::SETTLE;
                end
            end
            DECIDE: begin
                if (cmp_use_s) begin
                    code_nxt_s[idx_r] = 1'b0;
                end else begin
                    code_nxt_s[idx_r] = code_r[idx_r];
                end
                // Bits below the index are always zero, so setting the next
                // trial bit can never carry into the resolved bits.
                if (idx_r != IW'(0)) begin
                    code_nxt_s[idx_r - IW'(1)] = 1'b1;
                    idx_nxt_s   = idx_r - IW'(1);
                    cnt_nxt_s   = CNT_LOAD;
                    state_nxt_s = AFTER_TRIAL;
                end else begin
                    state_nxt_s = FINISH;
                end
            end
            FINISH: begin
                result_nxt_s = code_r;
                done_nxt_s   = 1'b1;
                busy_nxt_s   = 1'b0;
                state_nxt_s  = IDLE;
            end
            default: begin
                busy_nxt_s  = 1'b0;
                state_nxt_s = IDLE;
            end
        endcase
    end

    assign dac_code = code_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign result   = result_r;

endmodule

// File: tb/tb_sar_ctrl.sv
// Self-checking bench for sar_ctrl: two instances (SETTLE=2 and SETTLE=0)
// with ideal comparators, checked against a binary-search reference model.
module tb_sar_ctrl;

`ifdef SAR_CTRL_CMP_SYNC_EN
    localparam int SYNC_X = 2;
`else
    localparam int SYNC_X = 0;
`endif
    localparam int PB_A  = 2 + 1 + SYNC_X;
    localparam int PB_B  = 0 + 1 + SYNC_X;
    localparam int LAT_A = 8 * PB_A + 1;
    localparam int NB2B  = 512;

    logic       clk;
    logic       rst;
    logic       start_a, start_b;
    logic [7:0] vin_a, vin_b;
    logic       cmp_a, cmp_b;
    logic [7:0] dac_a, dac_b, res_a, res_b;
    logic       busy_a, busy_b, done_a, done_b;

    int n_checks = 0;
    int n_errors = 0;

    sar_ctrl #(.N(8), .SETTLE(2)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .cmp_lt(cmp_a),
        .dac_code(dac_a), .busy(busy_a), .done(done_a), .result(res_a)
    );

    sar_ctrl #(.N(8), .SETTLE(0)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .cmp_lt(cmp_b),
        .dac_code(dac_b), .busy(busy_b), .done(done_b), .result(res_b)
    );

    // Ideal comparators: input below the current trial code.
    assign cmp_a = (vin_a < dac_a);
    assign cmp_b = (vin_b < dac_b);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Trial code presented for step j of an ideal binary search on v:
    // the already-resolved upper bits of v plus the bit under test.
    function automatic logic [7:0] exp_trial(input logic [7:0] v, input int j);
        int         k;
        logic [8:0] hi_mask;
        logic [7:0] bit_v;
        k       = 7 - j;
        hi_mask = 9'h1FF << (k + 1);
        bit_v   = 8'h01 << k;
        return (v & hi_mask[7:0]) | bit_v;
    endfunction

    // One conversion with a single start pulse on instance a (sel=0) or b (sel=1).
    task automatic run_conv(input bit sel, input logic [7:0] v, input bit trials, input bit repulse);
        int         pb, lat, busy_cnt, done_cnt, done_edge;
        logic [7:0] code_s, res_s;
        logic       busy_s, done_s;
        pb        = sel ? PB_B : PB_A;
        lat       = 8 * pb + 1;
        busy_cnt  = 0;
        done_cnt  = 0;
        done_edge = -1;
        if (sel) begin
            vin_b   = v;
            start_b = 1'b1;
        end else begin
            vin_a   = v;
            start_a = 1'b1;
        end
        for (int e = 0; e <= lat + 2; e++) begin
            @(posedge clk);
            #1;
            if (e == 0) begin
                start_a = 1'b0;
                start_b = 1'b0;
            end
            code_s = sel ? dac_b  : dac_a;
            busy_s = sel ? busy_b : busy_a;
            done_s = sel ? done_b : done_a;
            if (busy_s) busy_cnt++;
            if (done_s) begin
                done_cnt++;
                if (done_edge < 0) done_edge = e;
            end
            if (trials && (e % pb == 0) && (e / pb < 8)) begin
                check_eq($sformatf("trial%0d_v%0h", e / pb, v), 32'(code_s), 32'(exp_trial(v, e / pb)));
            end
            if (repulse && e == 9)  start_a = 1'b1;
            if (repulse && e == 10) start_a = 1'b0;
        end
        res_s = sel ? res_b : res_a;
        check_eq($sformatf("done_count_v%0h", v), 32'(done_cnt), 32'(1));
        check_eq($sformatf("latency_v%0h", v), 32'(done_edge), 32'(lat));
        check_eq($sformatf("busy_cycles_v%0h", v), 32'(busy_cnt), 32'(lat));
        check_eq($sformatf("result_v%0h", v), 32'(res_s), 32'(v));
    endtask

    initial begin
        logic [7:0] v;
        logic [7:0] q[$];
        logic [7:0] exp_v;
        int         cnt, cyc, prev, n_done;

        rst     = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        vin_a   = 8'h00;
        vin_b   = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_dac", 32'(dac_a), 32'(0));
        check_eq("reset_busy", 32'(busy_a), 32'(0));
        check_eq("reset_done", 32'(done_a), 32'(0));
        check_eq("reset_result", 32'(res_a), 32'(0));
        check_eq("reset_dac_b", 32'(dac_b), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Main conversions and boundaries on the SETTLE=2 instance.
        run_conv(1'b0, 8'hA5, 1'b1, 1'b0);
        run_conv(1'b0, 8'h00, 1'b1, 1'b0);
        run_conv(1'b0, 8'hFF, 1'b1, 1'b0);
        run_conv(1'b0, 8'h3C, 1'b1, 1'b1);

        // Asynchronous reset in the middle of a conversion.
        vin_a   = 8'h5A;
        start_a = 1'b1;
        for (int e = 0; e <= 12; e++) begin
            @(posedge clk);
            #1;
            if (e == 0) start_a = 1'b0;
        end
        #2;
        rst = 1'b1;
        #1;
        check_eq("abort_dac", 32'(dac_a), 32'(0));
        check_eq("abort_busy", 32'(busy_a), 32'(0));
        check_eq("abort_done", 32'(done_a), 32'(0));
        check_eq("abort_result", 32'(res_a), 32'(0));
        @(negedge clk);
        @(negedge clk);
        rst    = 1'b0;
        n_done = 0;
        for (int i = 0; i < 2 * LAT_A; i++) begin
            @(posedge clk);
            #1;
            if (done_a) n_done++;
        end
        check_eq("abort_no_done", 32'(n_done), 32'(0));
        check_eq("abort_result_held", 32'(res_a), 32'(0));
        run_conv(1'b0, 8'h96, 1'b1, 1'b0);

        // Back-to-back conversions with start held high.
        v = 8'($urandom_range(0, 255));
        vin_a = v;
        q.push_back(v);
        start_a = 1'b1;
        cnt  = 0;
        cyc  = 0;
        prev = -1;
        while (cnt < NB2B && cyc < NB2B * (LAT_A + 1) + 100) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done_a) begin
                exp_v = q.pop_front();
                check_eq($sformatf("b2b_result_%0d", cnt), 32'(res_a), 32'(exp_v));
                if (prev >= 0) begin
                    check_eq($sformatf("b2b_gap_%0d", cnt), 32'(cyc - prev), 32'(LAT_A + 1));
                end
                prev = cyc;
                cnt++;
                if (cnt < NB2B) begin
                    v = 8'($urandom_range(0, 255));
                    vin_a = v;
                    q.push_back(v);
                end else begin
                    start_a = 1'b0;
                end
            end
        end
        start_a = 1'b0;
        check_eq("b2b_count", 32'(cnt), 32'(NB2B));
        repeat (LAT_A + 2) @(posedge clk);
        #1;

        // SETTLE=0 instance.
        run_conv(1'b1, 8'h00, 1'b1, 1'b0);
        run_conv(1'b1, 8'hFF, 1'b1, 1'b0);
        run_conv(1'b1, 8'h5C, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            run_conv(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/sar_ctrl.md
Name: sar_ctrl

Overview:
Successive-approximation controller. It drives a trial code to an external DAC or digital model and consumes the single-bit decision of a comparator (comp_lt semantics: input < trial code). It resolves an N-bit result MSB-first. It sits on the consuming end of the common comparator cells, between the comparator output and the register or data path that reads the conversion.

Parameters:
N, 8, result/trial code width (N >= 2)
SETTLE, 2, wait cycles after each trial-code update before the decision is sampled (>= 0)

Ports:
clk  input  1  clock, rising-edge
rst  input  1  reset, asynchronous, active-high
start  input  1  conversion request, level-sampled in IDLE only
cmp_lt  input  1  comparator decision: 1 = input below current dac_code
dac_code  output  N  current trial code
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse when result is valid
result  output  N  last completed conversion, held until the next done

Behaviour:
- Interface: one clock clk; reset rst is asynchronous and active-high.
- Reset (async assert, sync release): state=IDLE, dac_code=0, busy=0, done=0, result=0, bit index=N-1, settle counter=0.
- FSM states: IDLE, SETTLE, DECIDE, FINISH.
- IDLE:
  - start=1 at an edge -> dac_code={1'b1, (N-1)'b0}, bit index=N-1, counter=SETTLE, busy=1.
  - Next state is SETTLE if SETTLE>0, else DECIDE.
- SETTLE: counter decrements each cycle. At counter==1 the next state is DECIDE. cmp_lt is ignored.
- DECIDE:
  - Sample cmp_lt. If 1, clear dac_code[bit index]; else keep it.
  - If bit index>0: set dac_code[bit index-1]=1, decrement index, reload counter, go to SETTLE (or DECIDE if SETTLE=0).
  - If bit index==0: go to FINISH.
- FINISH: result<=final code, done=1 for this single cycle, busy=0. Next state IDLE. dac_code holds the final code.
- Latency: the edge that samples start is edge 0. Each bit takes SETTLE+1 cycles. done is high in the cycle after edge N*(SETTLE+1)+1. For N=8, SETTLE=2 that is 25 edges.
- start while busy or in FINISH: ignored, no queuing. start held high continuously gives back-to-back conversions, with start re-accepted in the IDLE cycle after FINISH.
- Reset mid-conversion: immediate abort to reset values. No done is issued and result is cleared.
- Arithmetic: dac_code only ever has bits set at or above the bit index. No carries or overflow are possible.
- Decision convention: for an ideal comparator with input v in [0, 2^N-1], result==v exactly.

Optional Feature:
SAR_CTRL_CMP_SYNC_EN
- Defined: cmp_lt passes through a 2-flop synchronizer (reset to 0) before use. Every per-bit wait is extended by 2 cycles (SETTLE+2 counted), so per-bit cost is SETTLE+3 and total latency is N*(SETTLE+3)+1.
- Undefined: cmp_lt is used directly and the latency is as stated above. Ports are identical in both builds.

Decomposition:
- Package sar_ctrl_pkg holds:
  - typedef enum logic [1:0] sar_state_t {IDLE, SETTLE, DECIDE, FINISH};
  - function sar_latency(N, SETTLE, sync), which returns the cycle count used by the bench.
- Sub-module sync_2ff (1-bit, async active-high reset) is instantiated only under SAR_CTRL_CMP_SYNC_EN.
- The bit-index and settle counters stay inline.

Test Plan:
- Bench: behavioural comparator cmp_lt = (vin < dac_code), modelled with the existing comp_lt cell.
- N=8, SETTLE=2, vin=8'hA5, single start pulse -> done pulses once at edge 25, result=8'hA5, busy high for exactly 25 cycles, trial sequence starts 80, C0, A0, B0.
- Boundaries: vin=0 -> result 0 with every trial bit cleared. vin=8'hFF -> result FF. Both at 25-cycle latency.
- start pulsed again at cycle 10 of a conversion (vin=8'h3C) -> ignored, exactly one done, result 3C. start held high with vin stepping 512 random values -> one done per conversion, every result==vin.
- rst asserted asynchronously mid-conversion (between edges, cycle 12) -> outputs reset before the next edge, no done, result=0. The next start converts correctly.
- SETTLE=0 and SAR_CTRL_CMP_SYNC_EN toggled: N=8 latency is 9 (plain) and 25 (sync) edges, result==vin in both builds.
